calc_top: RTL and testbench

//  Top level of a DE10-Lite 4-bit integer calculator. Operands come from switches; an

---
 rtl/calc_top_if.sv | 26 ++
 rtl/calc_top.sv | 178 +++++++++++++++++
 tb/tb_calc_top.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_top_if.sv
// Board-facing signal bundle for the 4-bit calculator: switches and keys in,
// LEDs, seven-segment digits and raw debug buses out. The design side uses "slave".
interface calc_top_if;
    logic [9:0] SW;
    logic [1:0] KEY;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;
    logic [9:0] LEDR;
    logic [3:0] addSum;
    logic [3:0] cs;
    logic [7:0] multOut;
    logic [5:0] diviOut;

    modport master (
        output SW, KEY,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR, addSum, cs, multOut, diviOut
    );
    modport slave (
        input  SW, KEY,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR, addSum, cs, multOut, diviOut
    );
endinterface

// File: rtl/calc_top.sv
// DE10-Lite 4-bit calculator: key-stepped operation FSM, latched result, 7-seg display.
// Optional key debounce is enabled by defining DEBOUNCE_EN.
module calc_top
`ifdef DEBOUNCE_EN
    #(parameter int DEBOUNCE_CYCLES = 500000)
`endif
(
    input logic       MAX10_CLK1_50,
    calc_top_if.slave bus
);

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_SQR, OP_SQRT, OP_MAX
    } op_e;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       sw8_unused;

    assign clk        = MAX10_CLK1_50;
    assign rst        = bus.SW[9];
    assign a          = bus.SW[3:0];
    assign b          = bus.SW[7:4];
    assign sw8_unused = bus.SW[8];

    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] vld;
    logic [1:0] armed;
    logic [1:0] press;

    // armed stays low until a genuinely sampled high is seen, so a key held
    // down across reset release cannot produce a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            vld   <= 2'b00;
            armed <= 2'b00;
        end else begin
            sync1 <= bus.KEY;
            sync2 <= sync1;
            vld   <= {vld[0], 1'b1};
            armed <= armed | (vld[1] ? sync2 : 2'b00);
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] low_cnt [2];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst || sync2[i]) begin
                low_cnt[i] <= '0;
            end else if (low_cnt[i] != CW'(DEBOUNCE_CYCLES)) begin
                low_cnt[i] <= low_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        press = 2'b00;
        for (int i = 0; i < 2; i++) begin
            press[i] = armed[i] & ~sync2[i] & (low_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
        end
    end
`else
    logic [1:0] edge_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q <= 2'b11;
        end else begin
            edge_q <= sync2;
        end
    end

    assign press = armed & edge_q & ~sync2;
`endif

    op_e        state_q;
    op_e        state_d;
    logic [7:0] live;
    logic       dz;
    logic       neg;
    logic [7:0] latched;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OP_ADD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (press[0]) begin
            state_d = op_e'(state_q + 3'd1);
        end
    end

    always_comb begin
        live   = 8'd0;
        dz     = 1'b0;
        neg    = 1'b0;
        bus.cs = {1'b0, state_q};
        unique case (state_q)
            OP_ADD: live = {4'd0, a} + {4'd0, b};
            OP_SUB: begin
                neg  = (a < b);
                live = {4'd0, (a < b) ? (b - a) : (a - b)};
            end
            OP_MUL: live = {4'd0, a} * {4'd0, b};
            OP_DIV: begin
                dz   = (b == 4'd0);
                live = dz ? 8'hFF : {4'd0, a / b};
            end
            OP_MOD: begin
                dz   = (b == 4'd0);
                live = dz ? 8'hFF : {4'd0, a % b};
            end
            OP_SQR: live = {4'd0, a} * {4'd0, a};
            OP_SQRT: begin
                if (a >= 4'd9)      live = 8'd3;
                else if (a >= 4'd4) live = 8'd2;
                else if (a >= 4'd1) live = 8'd1;
                else                live = 8'd0;
            end
            OP_MAX: live = {4'd0, (a > b) ? a : b};
        endcase
    end

    // Latch samples the pre-advance state when both keys fire together.
    always_ff @(posedge clk) begin
        if (rst) begin
            latched <= 8'd0;
        end else if (press[1]) begin
            latched <= live;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign bus.HEX5    = hex7(a);
    assign bus.HEX4    = hex7(b);
    assign bus.HEX3    = hex7({1'b0, state_q});
    assign bus.HEX2    = 7'h7F;
    assign bus.HEX1    = hex7(latched[7:4]);
    assign bus.HEX0    = hex7(latched[3:0]);
    assign bus.LEDR    = {neg, dz, live};
    assign bus.addSum  = a + b;
    assign bus.multOut = {4'd0, a} * {4'd0, b};
    assign bus.diviOut = (b == 4'd0) ? 6'h3F : {2'b00, a / b};

endmodule

// File: tb/tb_calc_top.sv
// Self-checking bench for calc_top: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized keys/switches.
module tb_calc_top;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    calc_top_if bus();

    calc_top dut (
        .MAX10_CLK1_50(clk),
        .bus          (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] live_f(input int op, input int a, input int b);
        int r;
        case (op)
            0: return 8'(a + b);
            1: return 8'((a >= b) ? a - b : b - a);
            2: return 8'(a * b);
            3: return (b == 0) ? 8'hFF : 8'(a / b);
            4: return (b == 0) ? 8'hFF : 8'(a % b);
            5: return 8'(a * a);
            6: begin
                r = 0;
                while ((r + 1) * (r + 1) <= a) r++;
                return 8'(r);
            end
            default: return 8'((a > b) ? a : b);
        endcase
    endfunction

    // Behavioural model: a press is a fall between two samples taken after reset,
    // taking effect on the third rising edge after the fall.
    int         m_cs  = 0;
    logic [7:0] m_lat = 8'd0;
    int         m_nv  = 0;
    logic [1:0] h1, h2, h3;
    bit         m_ok  = 1'b0;

    always @(posedge clk) begin
        if (bus.SW[9]) begin
            m_cs  = 0;
            m_lat = 8'd0;
            m_nv  = 0;
            m_ok  = 1'b1;
        end else begin
            if (m_nv >= 3 && h3[1] && !h2[1]) m_lat = live_f(m_cs, bus.SW[3:0], bus.SW[7:4]);
            if (m_nv >= 3 && h3[0] && !h2[0]) m_cs = (m_cs + 1) % 8;
            h3 = h2;
            h2 = h1;
            h1 = bus.KEY;
            m_nv++;
        end
    end

    always @(negedge clk) begin
        int a, b;
        logic [9:0] exp_ledr;
        if (m_ok) begin
            a = bus.SW[3:0];
            b = bus.SW[7:4];
            exp_ledr = {(m_cs == 1 && a < b), ((m_cs == 3 || m_cs == 4) && b == 0),
                        live_f(m_cs, a, b)};
            chk("cs", bus.cs, 64'(m_cs));
            chk("ledr", bus.LEDR, exp_ledr);
            chk("addsum", bus.addSum, 64'((a + b) % 16));
            chk("multout", bus.multOut, 64'(a * b));
            chk("diviout", bus.diviOut, (b == 0) ? 64'h3F : 64'(a / b));
            chk("hex", {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0},
                {seg[a], seg[b], seg[m_cs], 7'h7F, seg[m_lat[7:4]], seg[m_lat[3:0]]});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k, input int w);
        bus.KEY[k] = 1'b0;
        cyc(w);
        bus.KEY[k] = 1'b1;
        cyc(4);
    endtask

    task automatic set_ab(input int a, input int b);
        bus.SW[7:0] = {4'(b), 4'(a)};
        cyc(1);
    endtask

    initial begin
        int n;
        bus.SW  = 10'h200;
        bus.KEY = 2'b11;
        cyc(3);
        bus.SW[9] = 1'b0;
        set_ab(7, 6);
        cyc(4);
        @(negedge clk);
        chk("lit_reset_cs", bus.cs, 0);
        chk("lit_reset_hex10", {bus.HEX1, bus.HEX0}, {7'h40, 7'h40});
        chk("lit_76_addsum", bus.addSum, 13);
        chk("lit_76_mult", bus.multOut, 42);
        chk("lit_76_divi", bus.diviOut, 1);
        chk("lit_76_ledr", bus.LEDR[7:0], 13);
        cyc(1);

        set_ab(6, 4);
        @(negedge clk);
        chk("lit_64_addsum", bus.addSum, 10);
        chk("lit_64_mult", bus.multOut, 24);
        chk("lit_64_divi", bus.diviOut, 1);
        cyc(1);
        for (int i = 0; i < 32; i++) press(i % 2, 2);
        @(negedge clk);
        chk("lit_wrap_cs", bus.cs, 0);
        cyc(1);

        set_ab(3, 0);
        repeat (3) press(0, 2);
        @(negedge clk);
        chk("lit_div_cs", bus.cs, 3);
        chk("lit_div0_divi", bus.diviOut, 6'h3F);
        chk("lit_div0_led8", bus.LEDR[8], 1);
        chk("lit_div0_res", bus.LEDR[7:0], 8'hFF);
        cyc(1);

        repeat (6) press(0, 2);
        set_ab(2, 9);
        @(negedge clk);
        chk("lit_sub_cs", bus.cs, 1);
        chk("lit_sub_res", bus.LEDR[7:0], 7);
        chk("lit_sub_neg", bus.LEDR[9], 1);
        cyc(1);
        press(1, 2);
        @(negedge clk);
        chk("lit_latch_hex1", bus.HEX1, 7'h40);
        chk("lit_latch_hex0", bus.HEX0, 7'h78);
        cyc(1);

        repeat (4) press(0, 2);
        @(negedge clk);
        chk("lit_pre_rst_cs", bus.cs, 5);
        cyc(1);
        bus.SW[9]  = 1'b1;
        bus.KEY[0] = 1'b0;
        cyc(1);
        bus.SW[9] = 1'b0;
        cyc(3);
        bus.KEY[0] = 1'b1;
        cyc(4);
        @(negedge clk);
        chk("lit_rst_cs", bus.cs, 0);
        chk("lit_rst_hex10", {bus.HEX1, bus.HEX0}, {7'h40, 7'h40});
        cyc(1);

        set_ab(15, 1);
        @(negedge clk);
        chk("lit_f1_addsum", bus.addSum, 0);
        chk("lit_f1_add", bus.LEDR[7:0], 16);
        cyc(1);
        repeat (6) press(0, 2);
        @(negedge clk);
        chk("lit_f1_sqrt", bus.LEDR[7:0], 3);
        cyc(1);
        press(0, 2);
        @(negedge clk);
        chk("lit_f1_max", bus.LEDR[7:0], 15);
        cyc(1);

        repeat (400) begin
            bus.SW[8:0] = 9'($urandom);
            bus.SW[9]   = ($urandom_range(0, 40) == 0);
            bus.KEY     = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 4);
            cyc(n);
            bus.SW[9] = 1'b0;
        end
        bus.KEY = 2'b11;
        cyc(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
